// File: rtl/otube_reader.sv
// -----------------------------------------------------------------------------
// otube_reader
//
// Purpose:
//   Host-side reader for the tube-hit FIFO read port. Generates RD_CLK/RD_EN
//   strobes, waits for RD_VALID, captures the 16-bit OTUBE word, decodes it
//   into tube index and drift time, streams data words over a valid/ready
//   interface, and assembles 32-tube events closed by the 16'hFFFF terminator.
//
// Ports:
//   clk50          in   system clock (posedge)
//   rst_n          in   asynchronous active-low reset
//   RD_CLK         out  read strobe; rising edge with RD_EN high pops a word
//   RD_EN          out  read enable, high only around a strobe
//   RD_EMPTY       in   FIFO empty (asynchronous, double-synchronised)
//   RD_VALID       in   OTUBE holds a fresh word (asynchronous, double-synchronised)
//   OTUBE          in   [15:8] drift time, [7:0] tube name
//   enable         in   gate for starting new strobes
//   word_valid     out  decoded word available
//   word_ready     in   consumer accepts when word_valid && word_ready
//   word_time      out  drift time of the current word
//   word_tube      out  tube index 0..31
//   evt_valid      out  one-cycle pulse at event close
//   evt_hit_mask   out  bit n set when tube n had a nonzero time
//   evt_hit_count  out  popcount of evt_hit_mask
//   evt_err        out  [0] short event, [1] long event, [2] bad name seen
//   timeout_cnt    out  saturating count of RD_VALID timeouts
// -----------------------------------------------------------------------------
module otube_reader #(
    parameter int CLK_HI_CYC    = 4,
    parameter int CLK_LO_CYC    = 4,
    parameter int VALID_TIMEOUT = 64
) (
    input  logic        clk50,
    input  logic        rst_n,
    output logic        RD_CLK,
    output logic        RD_EN,
    input  logic        RD_EMPTY,
    input  logic        RD_VALID,
    input  logic [15:0] OTUBE,
    input  logic        enable,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  word_time,
    output logic [4:0]  word_tube,
    output logic        evt_valid,
    output logic [31:0] evt_hit_mask,
    output logic [5:0]  evt_hit_count,
    output logic [2:0]  evt_err,
    output logic [7:0]  timeout_cnt
);

    // One-hot encoding keeps RD_CLK a direct decode of a single state flop.
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_HI   = 5'b00010,
        S_LO   = 5'b00100,
        S_WAIT = 5'b01000,
        S_DEC  = 5'b10000
    } state_t;

    localparam logic [15:0] HI_LAST = 16'(CLK_HI_CYC - 1);
    localparam logic [15:0] LO_LAST = 16'(CLK_LO_CYC - 1);
    localparam logic [15:0] TO_LAST = 16'(VALID_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;

    logic [1:0]  r_empty_sync;
    logic [1:0]  r_valid_sync;
    logic        w_empty_s;
    logic        w_valid_s;

    logic [15:0] r_hold;
    logic        r_word_valid;
    logic [7:0]  r_word_time;
    logic [4:0]  r_word_tube;
    logic        r_evt_valid;
    logic [31:0] r_evt_mask;
    logic [5:0]  r_evt_count;
    logic [2:0]  r_evt_err;
    logic [7:0]  r_timeout_cnt;

    // Event accumulators
    logic [31:0] r_mask;
    logic [5:0]  r_word_cnt;
    logic        r_bad;

    logic        w_is_term;
    logic        w_name_ok;
    logic [4:0]  w_tube;
    logic [31:0] w_mask_next;
    logic [5:0]  w_popcnt;
    logic        w_timeout;

    // ------------------------------------------------------------------
    // Input synchronisers. Empty resets to 1 so nothing is strobed until
    // the real FIFO status has propagated.
    // ------------------------------------------------------------------
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_empty_sync <= 2'b11;
            r_valid_sync <= 2'b00;
        end else begin
            r_empty_sync <= {r_empty_sync[0], RD_EMPTY};
            r_valid_sync <= {r_valid_sync[0], RD_VALID};
        end
    end

    assign w_empty_s = r_empty_sync[1];
    assign w_valid_s = r_valid_sync[1];

    // ------------------------------------------------------------------
    // FSM: state register. The phase counter restarts on every state change.
    // ------------------------------------------------------------------
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? 16'd0 : r_cnt + 16'd1;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // A pending word that is being accepted this cycle does not block.
            S_IDLE: if (enable && !w_empty_s && (!r_word_valid || word_ready))
                        w_state_next = S_HI;
            S_HI:   if (r_cnt == HI_LAST) w_state_next = S_LO;
            S_LO:   if (r_cnt == LO_LAST) w_state_next = S_WAIT;
            S_WAIT: begin
                if (w_valid_s)
                    w_state_next = S_DEC;
                else if (r_cnt == TO_LAST)
                    w_state_next = S_IDLE;
            end
            S_DEC:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs. RD_EN overlaps the first low cycle so the FIFO sees
    // it stable across the falling edge of RD_CLK.
    always_comb begin
        RD_CLK = (r_state == S_HI);
        RD_EN  = (r_state == S_HI) || ((r_state == S_LO) && (r_cnt == 16'd0));
    end

    // ------------------------------------------------------------------
    // Word classification
    // ------------------------------------------------------------------
    assign w_is_term   = (r_hold == 16'hFFFF);
    assign w_name_ok   = (r_hold[3:0] == 4'h3) || (r_hold[3:0] == 4'h4);
    assign w_tube      = {r_hold[3:0] == 4'h4, r_hold[4], r_hold[7:5]};
    assign w_mask_next = r_mask | ((r_hold[15:8] != 8'd0) ? (32'd1 << w_tube) : 32'd0);
    assign w_timeout   = (r_state == S_WAIT) && !w_valid_s && (r_cnt == TO_LAST);

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < 32; i++)
            w_popcnt = w_popcnt + {5'd0, r_mask[i]};
    end

    // ------------------------------------------------------------------
    // Datapath: capture, stream register, event accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_hold        <= '0;
            r_word_valid  <= 1'b0;
            r_word_time   <= '0;
            r_word_tube   <= '0;
            r_evt_valid   <= 1'b0;
            r_evt_mask    <= '0;
            r_evt_count   <= '0;
            r_evt_err     <= '0;
            r_timeout_cnt <= '0;
            r_mask        <= '0;
            r_word_cnt    <= '0;
            r_bad         <= 1'b0;
        end else begin
            r_evt_valid <= 1'b0;

            if (r_word_valid && word_ready)
                r_word_valid <= 1'b0;

            if ((r_state == S_WAIT) && w_valid_s)
                r_hold <= OTUBE;

            if (w_timeout && (r_timeout_cnt != 8'hFF))
                r_timeout_cnt <= r_timeout_cnt + 8'd1;

            if (r_state == S_DEC) begin
                if (w_is_term) begin
                    // Terminators on an empty event are the writer's
                    // repeated trailers; they are swallowed.
                    if (r_word_cnt != 6'd0) begin
                        r_evt_valid <= 1'b1;
                        r_evt_mask  <= r_mask;
                        r_evt_count <= w_popcnt;
                        r_evt_err   <= {r_bad, r_word_cnt > 6'd32, r_word_cnt < 6'd32};
                        r_mask      <= '0;
                        r_word_cnt  <= '0;
                        r_bad       <= 1'b0;
                    end
                end else if (w_name_ok) begin
                    r_word_valid <= 1'b1;
                    r_word_time  <= r_hold[15:8];
                    r_word_tube  <= w_tube;
                    r_mask       <= w_mask_next;
                    if (r_word_cnt != 6'd63)
                        r_word_cnt <= r_word_cnt + 6'd1;
                end else begin
                    r_bad <= 1'b1;
                end
            end
        end
    end

    assign word_valid    = r_word_valid;
    assign word_time     = r_word_time;
    assign word_tube     = r_word_tube;
    assign evt_valid     = r_evt_valid;
    assign evt_hit_mask  = r_evt_mask;
    assign evt_hit_count = r_evt_count;
    assign evt_err       = r_evt_err;
    assign timeout_cnt   = r_timeout_cnt;

endmodule
